// File: rtl/qspi_flash_responder_pkg.sv
// Shared types and constants for the QSPI quad fast-read flash responder.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } qspi_state_t;

  localparam logic [7:0] CMD_QUAD_FAST_READ = 8'hEB;
  localparam logic [3:0] MODE_CONT          = 4'hA;
  localparam int         DEFAULT_DUMMY_CLKS = 4;

endpackage

// File: rtl/qspi_flash_responder_in_sync.sv
// Brings sck, ce_n and io[3:0] into the HCLK domain and flags sck edges.
// All three inputs travel through the same depth so a sampled nibble is
// aligned with the sck rise that qualifies it.
module qspi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       ce_n_s,
  output logic [3:0] din_s
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ce_sr;
  logic [3:0]             din_sr [SYNC_STAGES];
  logic                   sck_d;

  // Synchronizer shift chains plus one extra sck flop for edge detection.
  always_ff @(posedge clk) begin
    sck_sr[0] <= sck;
    ce_sr[0]  <= ce_n;
    din_sr[0] <= din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sck_sr[i] <= sck_sr[i-1];
      ce_sr[i]  <= ce_sr[i-1];
      din_sr[i] <= din_sr[i-1];
    end
    sck_d <= sck_sr[SYNC_STAGES-1];
  end

  assign sck_rise = sck_sr[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_sr[SYNC_STAGES-1] & sck_d;
  assign ce_n_s   = ce_sr[SYNC_STAGES-1];
  assign din_s    = din_sr[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_flash_responder.sv
// Target end of a QSPI quad fast-read (0xEB) link. Decodes command, address,
// mode byte and dummy clocks from the oversampled bus, then streams bytes
// from a synchronous memory port, prefetching one byte ahead.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int         ADDR_W      = 24,
  parameter int         DUMMY_CLKS  = DEFAULT_DUMMY_CLKS,
  parameter logic [7:0] CMD_READ    = CMD_QUAD_FAST_READ,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              sck,
  input  logic              ce_n,
  input  logic [3:0]        din,
  output logic [3:0]        dout,
  output logic [3:0]        douten,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS - 1);

  logic              sck_rise, sck_fall, ce_n_s;
  logic [3:0]        din_s;
  qspi_state_t       state, state_n;
  logic [7:0]        cnt;
  logic [6:0]        cmd_sr;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        mode_hi;
  logic              cont_mode, ce_prev, ce_fall, nib_hi;
  logic [7:0]        byte_buf, pre_buf;
  logic              fetch, fetch_first, err;
  logic              rd_first_p0, rd_first_p1, rd_pre_p0, rd_pre_p1;

  qspi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
    .clk      (HCLK),
    .sck      (sck),
    .ce_n     (ce_n),
    .din      (din),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ce_n_s   (ce_n_s),
    .din_s    (din_s)
  );

  // ce_prev resets low so a ce_n still held low after reset is not a new frame.
  assign ce_fall = ce_prev & ~ce_n_s;

  // Next-state decode; also flags memory fetches and opcode errors.
  always_comb begin
    state_n     = state;
    fetch       = 1'b0;
    fetch_first = 1'b0;
    err         = 1'b0;
    if (ce_n_s) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (ce_fall) state_n = cont_mode ? ADDR : CMD;
        CMD: if (sck_rise && cnt == 8'd7) begin
          if ({cmd_sr, din_s[0]} == CMD_READ) begin
            state_n = ADDR;
          end else begin
            state_n = IGNORE;
            err     = 1'b1;
          end
        end
        ADDR: if (sck_rise && cnt == ADDR_LAST) state_n = MODE;
        MODE: if (sck_rise && cnt == 8'd1) begin
          if (DUMMY_CLKS == 0) begin
            state_n     = DATA;
            fetch       = 1'b1;
            fetch_first = 1'b1;
          end else begin
            state_n = DUMMY;
          end
        end
        DUMMY: if (sck_rise && cnt == DUMMY_LAST) begin
          state_n     = DATA;
          fetch       = 1'b1;
          fetch_first = 1'b1;
        end
        DATA: if (sck_fall && nib_hi) fetch = 1'b1;
        IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_n;
  end

  // Field capture, memory fetch pipeline and nibble output.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dout        <= 4'h0;
      douten      <= 4'h0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      cont_mode   <= 1'b0;
      ce_prev     <= 1'b0;
      cnt         <= '0;
      nib_hi      <= 1'b1;
      rd_first_p0 <= 1'b0;
      rd_first_p1 <= 1'b0;
      rd_pre_p0   <= 1'b0;
      rd_pre_p1   <= 1'b0;
    end else begin
      busy    <= ~ce_n_s;
      ce_prev <= ce_n_s;
      cmd_err <= err;
      mem_rd  <= fetch;

      if (state_n != state) cnt <= '0;
      else if (sck_rise)    cnt <= cnt + 8'd1;

      if (sck_rise && !ce_n_s) begin
        case (state)
          CMD:  cmd_sr <= {cmd_sr[5:0], din_s[0]};
          ADDR: addr   <= {addr[ADDR_W-5:0], din_s};
          MODE: begin
            if (cnt == 8'd0) mode_hi   <= din_s;
            else             cont_mode <= (mode_hi == MODE_CONT);
          end
          default: ;
        endcase
      end

      // Stage p0: strobe issued; stage p1: memory data valid, capture it.
      if (fetch) begin
        if (fetch_first) begin
          mem_addr <= addr;
        end else begin
          mem_addr <= addr + 1'b1;
          addr     <= addr + 1'b1;
        end
      end
      rd_first_p0 <= fetch & fetch_first;
      rd_pre_p0   <= fetch & ~fetch_first;
      rd_first_p1 <= rd_first_p0;
      rd_pre_p1   <= rd_pre_p0;
      if (rd_first_p1) byte_buf <= mem_rdata;
      if (rd_pre_p1)   pre_buf  <= mem_rdata;

      if (state_n != DATA) begin
        douten <= 4'h0;
        nib_hi <= 1'b1;
      end else if (state == DATA && sck_fall) begin
        douten <= 4'hF;
        if (nib_hi) begin
          dout <= byte_buf[7:4];
        end else begin
          dout     <= byte_buf[3:0];
          byte_buf <= pre_buf;
        end
        nib_hi <= ~nib_hi;
      end
    end
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable QSPI flash responder: the target end of the quad fast-read (0xEB) link driven by QSPI_XIP_CTRL.
- Oversamples sck/ce_n/io in the HCLK domain and decodes command, address, mode byte and dummy cycles.
- Returns bytes from a simple synchronous memory read port.
- Used as an on-chip boot-ROM or flash emulator, and as a synthesizable stand-in for the flash model in SoC benches.

Parameters:
- ADDR_W, 24: byte-address width on the QSPI link and on mem_addr.
- DUMMY_CLKS, 4: sck cycles between the mode byte and the first data nibble.
- CMD_READ, 8'hEB: the only accepted opcode.
- SYNC_STAGES, 2: synchronizer depth on sck, ce_n and din.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous active-low reset.
- sck  in  1  QSPI serial clock from the initiator (SPI mode 0).
- ce_n  in  1  chip enable, active low.
- din  in  4  io[3:0] as seen at the pads.
- dout  out  4  read-data nibble.
- douten  out  4  per-line output enable (1 = drive).
- mem_addr  out  ADDR_W  memory byte address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- busy  out  1  high while ce_n is low (synchronized).
- cmd_err  out  1  one-cycle pulse when an unsupported opcode is received.

Behaviour:
- Clock and reset: one clock HCLK; reset is synchronous, active-low on HRESETn.
- Reset values: dout=0, douten=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0, state=IDLE, cont_mode=0.
- Input sync:
  - sck, ce_n and din pass through SYNC_STAGES flops.
  - Edge detect on synchronized sck: rise = sample, fall = shift out.
  - Timing requirement: sck high and low phases each >= SYNC_STAGES+3 HCLK cycles.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
  - IDLE: on ce_n falling, go to CMD, or to ADDR if cont_mode=1. Clear the bit counter.
  - CMD: 8 rises sampling din[0], MSB first. Value == CMD_READ goes to ADDR. Any other value pulses cmd_err once and goes to IGNORE.
  - ADDR: ADDR_W/4 rises sampling din[3:0], MSB nibble first, into addr.
  - MODE: 2 rises; mode[7:4]==4'hA sets cont_mode, otherwise cont_mode is cleared.
  - DUMMY: DUMMY_CLKS rises.
    - On the HCLK cycle of the last rise: mem_rd=1, mem_addr=addr.
    - The following cycle latches mem_rdata into the byte buffer.
    - For DUMMY_CLKS=0, the fetch is issued on the last MODE rise instead.
  - DATA:
    - On the first fall after entering DATA: douten=4'hF, dout=buf[7:4].
    - Next fall: dout=buf[3:0].
    - Alternating falls continue indefinitely, high nibble first.
    - After the high nibble is driven, prefetch addr+1 (mem_rd pulse); the result loads on the following low-to-high nibble boundary.
    - Address wraps modulo 2^ADDR_W.
  - IGNORE: outputs stay disabled until ce_n goes high.
- ce_n high (synchronized) in any state:
  - Next cycle: state=IDLE, douten=0, mem_rd=0.
  - cont_mode is preserved.
  - A partial byte or nibble is discarded.
- Output latency: dout changes within SYNC_STAGES+2 HCLK cycles of the sck falling edge at the pin.
- mem_rd is never asserted on two consecutive cycles.
- mem_addr holds its value between strobes.
- HRESETn low mid-transaction: returns to reset values immediately on the next HCLK edge, including cont_mode=0.

Decomposition:
- Package qspi_pkg holds:
  - state enum qspi_state_t (IDLE..IGNORE);
  - constants CMD_QUAD_FAST_READ=8'hEB and MODE_CONT=4'hA;
  - default DUMMY_CLKS.
- One natural sub-module, qspi_in_sync: SYNC_STAGES synchronizer plus sck rise/fall edge detector. It outputs sck_rise, sck_fall, ce_n_s and din_s.

Test Plan:
- Basic read: HCLK=100MHz, sck=10MHz. Memory 0x000100=0xDE, 0x000101=0xAD. Send EB, addr 000100, mode 00, 4 dummy clocks, 4 data clocks -> dout nibbles D,E,A,D; douten=F only during data; cont_mode=0.
- Wrap-around: read at addr 0xFFFFFF with 4 data clocks; 0xFFFFFF=0x12, 0x000000=0x34 -> nibbles 1,2,3,4; mem_addr sequence FFFFFF then 000000.
- Bad opcode: send 0x03 -> cmd_err pulses exactly 1 cycle; douten stays 0; mem_rd never asserts; ce_n high then EB read works normally.
- Continuous mode: first transaction with mode A0 at addr 000010 -> cont_mode=1. Next ce_n low starts directly with 6 address clocks 000020 -> returns mem[0x20]. A following transaction with mode 00 clears cont_mode.
- Abort: raise ce_n after the 3rd address nibble -> within SYNC_STAGES+1 cycles state=IDLE, douten=0. Next full EB read at 000004 returns correct data.
- Reset mid-data: HRESETn low for 1 cycle during DATA -> all outputs return to reset values next cycle; cont_mode=0; transaction ignored until ce_n cycles high then low.
